and_subset_stream: RTL

//   Parametrised, sequential successor to the fixed 4-input subset-AND benchmark.

---
 rtl/and_subset_stream.sv | 130 +++++++++++++
 1 files changed

// File: rtl/and_subset_stream.sv
// Streams every K-of-N subset mask of a captured operand word, one per beat,
// in ascending mask order, with the AND of the selected operand bits.
module and_subset_stream #(
    parameter int N = 4,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_mask,
    output logic         out_and,
    output logic [N-1:0] out_index,
    output logic         out_last,
    output logic         busy
);

    if (N < 1 || N > 16 || K < 1 || K > N) begin : g_bad_param
        $error("and_subset_stream: N must be 1..16 and K must be 1..N");
    end

    function automatic logic [N-1:0] first_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < K; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [N-1:0] FIRST = first_mask();
    localparam logic [N-1:0] LAST  = FIRST << (N - K);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       r_state, w_state_next;
    logic [N-1:0] r_data, w_data_next;
    logic [N-1:0] r_mask, w_mask_next;
    logic [N-1:0] r_index, w_index_next;

    logic         w_run;
    logic         w_is_last;
    logic [N-1:0] w_sel;
    logic [4:0]   w_tz;
    logic [N-1:0] w_low;
    logic [N-1:0] w_ripple;
    logic [N-1:0] w_ones;
    logic [N-1:0] w_mask_succ;

    // Unselected positions read as 1 so the reduction AND covers only the subset.
    for (genvar gi = 0; gi < N; gi++) begin : g_sel
        assign w_sel[gi] = r_data[gi] | ~r_mask[gi];
    end

    // Gosper successor; the divide by the lowest set bit becomes a shift by its index.
    always_comb begin
        w_tz = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_mask[i]) w_tz = 5'(i);
        end
    end

    assign w_low       = r_mask & (~r_mask + N'(1));
    assign w_ripple    = r_mask + w_low;
    assign w_ones      = ((w_ripple ^ r_mask) >> 2) >> w_tz;
    assign w_mask_succ = w_ripple | w_ones;

    assign w_run     = (r_state == S_RUN);
    assign w_is_last = (r_mask == LAST);

    always_comb begin
        w_state_next = r_state;
        w_data_next  = r_data;
        w_mask_next  = r_mask;
        w_index_next = r_index;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_RUN;
                    w_data_next  = in_data;
                    w_mask_next  = FIRST;
                    w_index_next = '0;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (w_is_last) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_mask_next  = w_mask_succ;
                        w_index_next = r_index + N'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Abort outranks both a pending fire and a pending accept.
        if (flush) begin
            w_state_next = S_IDLE;
            w_data_next  = r_data;
            w_mask_next  = '0;
            w_index_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mask  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_data  <= w_data_next;
            r_mask  <= w_mask_next;
            r_index <= w_index_next;
        end
    end

    assign in_ready  = ~w_run;
    assign out_valid = w_run;
    assign busy      = w_run;
    assign out_mask  = w_run ? r_mask : '0;
    assign out_index = w_run ? r_index : '0;
    assign out_and   = w_run & (&w_sel);
    assign out_last  = w_run & w_is_last;

endmodule
